// File: rtl/regport_pkg.sv
// Shared definitions for the AXI4-Lite to register-port bridge.
package regport_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ISSUE,
        ST_WR_RESP,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_RESP
    } state_e;

    // Register addresses must be word aligned and not beyond the last register.
    function automatic logic addr_valid(input logic [31:0] addr, input logic [31:0] max);
        return (addr[1:0] == 2'b00) && (addr <= max);
    endfunction

endpackage

// File: rtl/axil_hold_buf.sv
// One-entry holding register for an AXI channel. The entry stays occupied
// until the owner signals that the transaction using it has completed.
module axil_hold_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Next-state: capture on handshake, release on completion. Ready is
    // registered so it reads 0 while reset is asserted.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid && ready_q) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (clear) begin
            valid_d = 1'b0;
        end
        ready_d = ~valid_d;
    end

    // Entry state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/axil_regport_bridge.sv
// AXI4-Lite slave that serialises host reads and writes onto the single-port
// register interface of a generated register file.
module axil_regport_bridge
    import regport_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MAX   = 8'h14,
    parameter int unsigned           RD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    output logic                      wr_en,
    output logic [ADDR_WIDTH-1:0]     wr_addr,
    output logic [DATA_WIDTH-1:0]     wr_data,
    output logic [DATA_WIDTH/8-1:0]   wr_be,
    output logic                      rd_en,
    output logic [ADDR_WIDTH-1:0]     rd_addr,
    input  logic [DATA_WIDTH-1:0]     rd_data
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    logic                    prefer_wr_q, prefer_wr_d;
    logic [1:0]              wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                    aw_valid, w_valid, ar_valid;
    logic [ADDR_WIDTH-1:0]   aw_addr, ar_addr;
    logic [DATA_WIDTH+STRB_W-1:0] w_bundle;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [STRB_W-1:0]       w_strb;
    logic                    wr_clear, ar_clear;
    logic                    aw_ok, ar_ok;
    logic                    wr_eligible, rd_eligible;

    axil_hold_buf #(.WIDTH(ADDR_WIDTH)) u_aw_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (awaddr),
        .in_valid  (awvalid),
        .in_ready  (awready),
        .clear     (wr_clear),
        .out_valid (aw_valid),
        .out_data  (aw_addr)
    );

    axil_hold_buf #(.WIDTH(DATA_WIDTH + STRB_W)) u_w_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   ({wstrb, wdata}),
        .in_valid  (wvalid),
        .in_ready  (wready),
        .clear     (wr_clear),
        .out_valid (w_valid),
        .out_data  (w_bundle)
    );

    axil_hold_buf #(.WIDTH(ADDR_WIDTH)) u_ar_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (araddr),
        .in_valid  (arvalid),
        .in_ready  (arready),
        .clear     (ar_clear),
        .out_valid (ar_valid),
        .out_data  (ar_addr)
    );

    assign w_data      = w_bundle[DATA_WIDTH-1:0];
    assign w_strb      = w_bundle[DATA_WIDTH+STRB_W-1:DATA_WIDTH];
    assign aw_ok       = addr_valid(32'(aw_addr), 32'(ADDR_MAX));
    assign ar_ok       = addr_valid(32'(ar_addr), 32'(ADDR_MAX));
    assign wr_eligible = aw_valid && w_valid;
    assign rd_eligible = ar_valid;

    // Register-side address/data come straight from the holding buffers.
    assign wr_addr = aw_addr;
    assign wr_data = w_data;
    assign wr_be   = w_strb;
    assign rd_addr = ar_addr;
    assign rdata   = rdata_q;

    // Arbitration, strobe generation, read-data alignment and responses.
    always_comb begin
        state_d     = state_q;
        prefer_wr_d = prefer_wr_q;
        wait_cnt_d  = wait_cnt_q;
        rdata_d     = rdata_q;
        wr_clear    = 1'b0;
        ar_clear    = 1'b0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        bvalid      = 1'b0;
        rvalid      = 1'b0;
        bresp       = RESP_OKAY;
        rresp       = RESP_OKAY;

        case (state_q)
            ST_IDLE: begin
                if (wr_eligible && (!rd_eligible || prefer_wr_q)) begin
                    state_d     = ST_WR_ISSUE;
                    prefer_wr_d = ~prefer_wr_q;
                end else if (rd_eligible) begin
                    state_d     = ST_RD_ISSUE;
                    prefer_wr_d = ~prefer_wr_q;
                end
            end
            ST_WR_ISSUE: begin
                wr_en   = aw_ok && (w_strb != '0);
                state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                bvalid = 1'b1;
                bresp  = aw_ok ? RESP_OKAY : RESP_SLVERR;
                if (bready) begin
                    wr_clear = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_RD_ISSUE: begin
                rd_en      = ar_ok;
                wait_cnt_d = '0;
                if (RD_LATENCY == 0) begin
                    rdata_d = ar_ok ? rd_data : '0;
                    state_d = ST_RD_RESP;
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                // Capture lands exactly RD_LATENCY cycles after the rd_en cycle.
                if ({30'd0, wait_cnt_q} == RD_LATENCY - 32'd1) begin
                    rdata_d = ar_ok ? rd_data : '0;
                    state_d = ST_RD_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            ST_RD_RESP: begin
                rvalid = 1'b1;
                rresp  = ar_ok ? RESP_OKAY : RESP_SLVERR;
                if (rready) begin
                    ar_clear = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and read-data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prefer_wr_q <= 1'b1;
            wait_cnt_q  <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            prefer_wr_q <= prefer_wr_d;
            wait_cnt_q  <= wait_cnt_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axil_regport_bridge.sv
// Directed bench for axil_regport_bridge: one instance with RD_LATENCY=1
// carries all checks, a second with RD_LATENCY=0 checks zero-latency reads.
module tb_axil_regport_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  awaddr, araddr;
    logic        awvalid, wvalid, arvalid, bready, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        awready, wready, arready, bvalid, rvalid, wr_en, rd_en;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, wr_data;
    logic [31:0] rd_data = 32'h1111_1111;
    logic [7:0]  wr_addr, rd_addr;
    logic [3:0]  wr_be;

    logic        awready0, wready0, arready0, bvalid0, rvalid0, wr_en0, rd_en0;
    logic [1:0]  bresp0, rresp0;
    logic [31:0] rdata0, wr_data0, rd_data0;
    logic [7:0]  wr_addr0, rd_addr0;
    logic [3:0]  wr_be0;

    axil_regport_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .ADDR_MAX(8'h14), .RD_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    axil_regport_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .ADDR_MAX(8'h14), .RD_LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready0),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready0),
        .bresp(bresp0), .bvalid(bvalid0), .bready(1'b1),
        .araddr(araddr), .arvalid(arvalid), .arready(arready0),
        .rdata(rdata0), .rresp(rresp0), .rvalid(rvalid0), .rready(1'b1),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_be(wr_be0),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0)
    );

    // Register-file read models: registered (latency 1) and combinational (latency 0).
    always @(posedge clk) rd_data <= rd_en ? 32'hDEAD_BEEF : 32'h1111_1111;
    assign rd_data0 = rd_en0 ? 32'hDEAD_BEEF : 32'h1111_1111;

    // Grant log for the latency-1 instance.
    byte         glog[$];
    int unsigned wr_cnt = 0;
    always @(posedge clk) begin
        if (wr_en) begin
            glog.push_back("W");
            wr_cnt = wr_cnt + 1;
        end
        if (rd_en) glog.push_back("R");
    end

    int unsigned ncmp = 0;
    int unsigned nfail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic send_both(input logic [7:0] wa, input logic [7:0] ra);
        awaddr = wa; wdata = 32'h0000_5500 | 32'(wa); wstrb = 4'hF;
        araddr = ra;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned base;
        string exp_s;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;

        // Reset state
        #12;
        check("rst_ready", {awready, wready, arready}, 64'd0);
        check("rst_valid_en", {bvalid, rvalid, wr_en, rd_en}, 64'd0);
        check("rst_resp_rdata", {bresp, rresp, rdata}, 64'd0);
        check("rst_wr_bus", {wr_addr, wr_data, wr_be}, 64'd0);
        check("rst_rd_addr", rd_addr, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        step();
        check("post_rst_ready", {awready, wready, arready}, 64'b111);

        // Write 0x04, AW and W together
        awaddr = 8'h04; wdata = 32'hA5A5_0001; wstrb = 4'b0011;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        check("t1_k_wren", wr_en, 64'd0);
        check("t1_k_ready", {awready, wready}, 64'd0);
        step();
        check("t1_k1_wren", wr_en, 64'd1);
        check("t1_k1_bus", {wr_addr, wr_data, wr_be}, {8'h04, 32'hA5A5_0001, 4'b0011});
        check("t1_k1_bvalid", bvalid, 64'd0);
        step();
        check("t1_k2_wren", wr_en, 64'd0);
        check("t1_k2_b", {bvalid, bresp}, {1'b1, 2'b00});
        step();
        check("t1_k3_bvalid", bvalid, 64'd0);
        check("t1_k3_awready", awready, 64'd1);

        // W three cycles ahead of AW, addr 0x00
        wdata = 32'h0000_0042; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        check("t2_w_held", {wready, awready}, 64'b01);
        step();
        check("t2_wait1_wren", wr_en, 64'd0);
        step();
        check("t2_wait2_wren", wr_en, 64'd0);
        awaddr = 8'h00; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        check("t2_j_wren", wr_en, 64'd0);
        step();
        check("t2_j1_wr", {wr_en, wr_addr, wr_data}, {1'b1, 8'h00, 32'h0000_0042});
        step();
        check("t2_j2_b", {bvalid, bresp}, {1'b1, 2'b00});
        step();
        check("t2_j3_bvalid", bvalid, 64'd0);

        // Read 0x08 on both latency variants
        araddr = 8'h08; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        check("t3_k_rden", {rd_en, rd_en0}, 64'd0);
        step();
        check("t3_k1_rd", {rd_en, rd_addr, rd_en0}, {1'b1, 8'h08, 1'b1});
        step();
        check("t3_k2_rvalid_l1", rvalid, 64'd0);
        check("t3_k2_r_l0", {rvalid0, rresp0, rdata0}, {1'b1, 2'b00, 32'hDEAD_BEEF});
        step();
        check("t3_k3_r_l1", {rvalid, rresp, rdata}, {1'b1, 2'b00, 32'hDEAD_BEEF});
        check("t3_k3_rvalid_l0", rvalid0, 64'd0);
        step();
        check("t3_k4_rvalid_l1", rvalid, 64'd0);

        // Out-of-range write and misaligned read
        awaddr = 8'h18; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        check("t4_wr_suppressed", wr_en, 64'd0);
        step();
        check("t4_bresp", {bvalid, bresp}, {1'b1, 2'b10});
        step();
        araddr = 8'h05; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        step();
        check("t4_rd_suppressed", rd_en, 64'd0);
        step();
        step();
        check("t4_rresp", {rvalid, rresp, rdata}, {1'b1, 2'b10, 32'h0});
        step();

        // Highest valid address reads normally
        araddr = 8'h14; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        step();
        check("t4_max_rden", {rd_en, rd_addr}, {1'b1, 8'h14});
        step();
        step();
        check("t4_max_r", {rvalid, rresp, rdata}, {1'b1, 2'b00, 32'hDEAD_BEEF});
        step();

        // Arbitration order
        glog.delete();
        send_both(8'h0C, 8'h10);
        idle_wait(10);
        send_both(8'h0C, 8'h10);
        idle_wait(10);
        araddr = 8'h10; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        idle_wait(8);
        send_both(8'h0C, 8'h10);
        idle_wait(10);
        exp_s = "WRWRRRW";
        check("t5_grant_count", glog.size(), 64'd7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t5_grant%0d", i), (i < glog.size()) ? glog[i] : 8'h3F, exp_s[i]);
        end

        // rready stalled for five cycles with a write waiting
        rready = 1'b0;
        araddr = 8'h08; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        step();
        check("t6_rden", rd_en, 64'd1);
        awaddr = 8'h0C; wdata = 32'h1234_5678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        base = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t6_stall%0d", i), {rvalid, rdata, wr_en}, {1'b1, 32'hDEAD_BEEF, 1'b0});
            step();
        end
        check("t6_no_grant", wr_cnt, 64'(base));
        rready = 1'b1;
        step();
        check("t6_rvalid_done", rvalid, 64'd0);
        step();
        check("t6_wr_after", {wr_en, wr_addr}, {1'b1, 8'h0C});
        idle_wait(4);

        // Reset during RD_WAIT with a write pending
        araddr = 8'h08; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        awaddr = 8'h04; wdata = 32'hCAFE_0000; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("t7_in_rst", {rvalid, arready, awready, wr_en, rd_en}, 64'd0);
        base = wr_cnt;
        @(negedge clk) rst_n = 1'b1;
        step();
        check("t7_ready_after", {awready, wready, arready}, 64'b111);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t7_quiet%0d", i), {rvalid, bvalid}, 64'd0);
            step();
        end
        check("t7_no_wr", wr_cnt, 64'(base));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
